// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci term collector: default geometry and
// the collector FSM state encoding.
package fib_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_DEPTH  = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    COLLECT  = 2'b01,
    DRAIN    = 2'b10,
    FINISHED = 2'b11
  } state_t;

endpackage

// File: rtl/fib_fifo.sv
// Synchronous FIFO with explicit occupancy tracking and a registered read port.
// The caller is trusted to gate wr_en/rd_en against full/empty.
module fib_fifo
  import fib_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  assign full  = (level == (ADDR_W+1)'(DEPTH));
  assign empty = (level == '0);

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge Clk) begin
    if (Reset || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: rtl/fib_term_collector.sv
// Collects the Fibonacci sequencer's term stream into a FIFO, flags 4-bit
// wrap and dropped terms, counts accepted terms and tracks session completion.
module fib_term_collector
  import fib_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              START,
  input  logic              term_valid,
  input  logic [DATA_W-1:0] term_in,
  input  logic              Done,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              dropped,
  output logic [CNT_W-1:0]  term_count,
  output logic              busy,
  output logic              fin
);

  state_t            state;
  state_t            next_state;
  logic              start_prev;
  logic              start_rise;
  logic              session_open;
  logic              wr_req;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] prev_term;
  logic              first_flag;

  assign start_rise   = START && !start_prev;
  assign session_open = (state == IDLE) && start_rise;

  // A pop frees a slot in the same cycle, so a write into a full FIFO still lands.
  assign wr_req = (state == COLLECT) && term_valid;
  assign rd_en  = (state != IDLE) && rd_req && !empty;
  assign wr_en  = wr_req && (!full || rd_en);

  always_ff @(posedge Clk) begin
    start_prev <= START;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    fin        = 1'b0;
    case (state)
      IDLE: begin
        if (start_rise) begin
          next_state = COLLECT;
        end
      end
      COLLECT: begin
        busy = 1'b1;
        if (Done) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (empty) begin
          next_state = FINISHED;
        end
      end
      FINISHED: begin
        fin = 1'b1;
        if (!START) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Session bookkeeping: wrap detection against the previous accepted term,
  // saturating term count and the sticky drop flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      overflow   <= 1'b0;
      dropped    <= 1'b0;
      term_count <= '0;
      prev_term  <= '0;
      first_flag <= 1'b1;
    end else if (session_open) begin
      overflow   <= 1'b0;
      dropped    <= 1'b0;
      term_count <= '0;
      first_flag <= 1'b1;
    end else begin
      if (wr_en) begin
        if (term_count != '1) begin
          term_count <= term_count + 1'b1;
        end
        if (!first_flag && (term_in < prev_term)) begin
          overflow <= 1'b1;
        end
        prev_term  <= term_in;
        first_flag <= 1'b0;
      end
      if (wr_req && !wr_en) begin
        dropped <= 1'b1;
      end
    end
  end

  fib_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .Clk      (Clk),
    .Reset    (Reset),
    .clr      (session_open),
    .wr_en    (wr_en),
    .wr_data  (term_in),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .level    (level),
    .full     (full),
    .empty    (empty)
  );

endmodule

// File: doc/fib_term_collector.md
Name: fib_term_collector

Overview:
- Downstream consumer of the Fibonacci sequencer's 4-bit term stream.
- Captures each term the sequencer produces into a small synchronous FIFO and exposes the terms to a reader through a pop handshake.
- Detects 4-bit arithmetic wrap in the sequence, counts accepted terms, and reports when a session has completed and the buffer has fully drained.

Parameters:
- DATA_W, 4, width of one term (matches the sequencer data bus).
- DEPTH, 8, FIFO entries; power of two.
- ADDR_W, 3, log2(DEPTH).
- CNT_W, 8, width of the term counter.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- START  in  1  level; a rising edge in IDLE opens a collection session.
- term_valid  in  1  one-cycle strobe; term_in holds a new term.
- term_in  in  DATA_W  term value from the sequencer.
- Done  in  1  level from the sequencer; high means no further terms.
- rd_req  in  1  reader pop request.
- rd_data  out  DATA_W  registered popped term.
- rd_valid  out  1  rd_data is valid this cycle.
- level  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- overflow  out  1  sticky; a wrap was detected this session.
- dropped  out  1  sticky; a term arrived while the FIFO was full.
- term_count  out  CNT_W  terms accepted this session; saturates at 2^CNT_W-1.
- busy  out  1  state is COLLECT or DRAIN.
- fin  out  1  state is FINISHED.

Behaviour:
- Reset (sync; also mid-session):
  - state=IDLE; FIFO pointers and level cleared.
  - rd_data=0, rd_valid=0, overflow=0, dropped=0, term_count=0.
  - prev term register cleared, first_flag=1.
  - A START already held high at reset release does not open a session; only a 0->1 edge does.
- States: IDLE, COLLECT, DRAIN, FINISHED.
  - IDLE -> COLLECT on a START rising edge. Entering COLLECT clears overflow, dropped, term_count and level, and sets first_flag=1.
  - COLLECT -> DRAIN when Done=1. A term_valid in that same cycle is still accepted.
  - DRAIN -> FINISHED when level==0 and no write is pending. If level is already 0 on entry, the transition happens on the next clock.
  - FINISHED -> IDLE when START=0.
  - START edges in COLLECT, DRAIN or FINISHED are ignored. Done is ignored in IDLE.
- Write rules:
  - Accepted only in COLLECT with term_valid=1.
  - If full and no simultaneous pop, the term is discarded, dropped is set, and term_count is unchanged.
  - Every accepted term increments term_count (saturating).
- Wrap detection:
  - On each accepted term with first_flag=0: if term_in < prev, set overflow.
  - prev <= term_in; first_flag <= 0.
  - Compare is unsigned, DATA_W bits.
- Read rules:
  - Accepted in COLLECT, DRAIN or FINISHED when rd_req=1 and empty=0.
  - rd_data/rd_valid appear the following cycle (latency 1).
  - rd_valid is high for exactly one cycle per accepted pop; rd_data holds its value otherwise.
  - rd_req while empty is ignored: no error, rd_valid=0.
- Simultaneous read and write:
  - Both accepted, level unchanged. This holds when full: the write is not dropped.
  - When empty: only the write is accepted; there is no bypass and rd_valid=0.
- Pointer wrap is modulo DEPTH; level is tracked explicitly so full and empty are unambiguous.

Decomposition:
- Package fib_pkg holds:
  - state encoding constants: IDLE=2'b00, COLLECT=2'b01, DRAIN=2'b10, FINISHED=2'b11;
  - default DATA_W and DEPTH.
- One sub-module, fib_fifo: synchronous FIFO with wr_en, rd_en, level, full, empty and registered rd_data.
- The top-level module holds the FSM, wrap detector, term counter and sticky flags.

Test Plan:
- Reset, then START 0->1, then 7 strobes with terms 1,1,2,3,5,8,13 -> level=7, term_count=7, overflow=0. Next strobe with term 5 (21 mod 16) -> overflow=1, level=8, full=1.
- With FIFO full, strobe term 2 with rd_req=0 -> dropped=1, level=8, term_count unchanged. Repeat with rd_req=1 in the same cycle -> level=8, dropped stays as before.
- Load 3 terms, assert Done, pop 3 times -> rd_data sequence matches write order, each one cycle after its rd_req. After the last pop, level=0, then fin=1. Drop START -> state IDLE, busy=0.
- rd_req with FIFO empty in COLLECT -> rd_valid stays 0, level=0.
- Assert Reset mid-COLLECT with level=5 and overflow=1 -> next cycle level=0, overflow=0, busy=0. A START held high does not restart until it toggles 0->1.
- Done=1 while in IDLE, and term_valid in IDLE -> state remains IDLE, level=0, term_count=0.
